// File: rtl/ram_nport.sv
// ram_nport: N-port byte-enabled synchronous RAM with priority write arbitration and a sequential clear engine
module ram_nport #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 8,
    parameter int BYTE_BITS = 8,
    parameter int NUM_WORDS = 2**ADDR_BITS,
    parameter int NUM_PORTS = 2,
    parameter int READ_LATENCY = 1,
    parameter bit WRITE_FIRST = 1'b0,
    parameter logic [WORD_BITS-1:0] INIT_WORD = '1
) (
    input  logic                                         in_clk,
    input  logic                                         in_rst,
    input  logic                                         in_clear,
    input  logic [NUM_PORTS-1:0]                         in_read_ena,
    input  logic [NUM_PORTS-1:0]                         in_write_ena,
    input  logic [NUM_PORTS*(WORD_BITS/BYTE_BITS)-1:0]   in_byte_ena,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]               in_addr,
    input  logic [NUM_PORTS*WORD_BITS-1:0]               in_data,
    output logic [NUM_PORTS*WORD_BITS-1:0]               out_data,
    output logic [NUM_PORTS-1:0]                         out_valid,
    output logic [NUM_PORTS-1:0]                         out_collision,
    output logic [NUM_PORTS-1:0]                         out_err,
    output logic                                         out_busy
);
    localparam int NUM_BYTES = WORD_BITS / BYTE_BITS;
    localparam int CNT_BITS = ADDR_BITS + 1;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                       state_q, state_d;
    logic [CNT_BITS-1:0]          cnt_q, cnt_d;
    logic [WORD_BITS-1:0]         mem_q [NUM_WORDS] = '{default: INIT_WORD};
    logic [WORD_BITS-1:0]         mem_d [NUM_WORDS];
    logic [NUM_PORTS*WORD_BITS-1:0] rd_data_q, rd_data_d;
    logic [NUM_PORTS-1:0]         rd_valid_q, rd_valid_d;
    logic [NUM_PORTS-1:0]         col_q, col_d, err_q, err_d;
    logic [ADDR_BITS-1:0]         addr [NUM_PORTS];
    logic [NUM_PORTS-1:0]         in_rng, lost;
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign addr[i] = in_addr[i*ADDR_BITS +: ADDR_BITS];
        assign in_rng[i] = int'(addr[i]) < NUM_WORDS;
    end
    // A writer loses to any lower-index port writing the same address, regardless of byte masks
    always_comb begin
        lost = '0;
        for (int p = 1; p < NUM_PORTS; p++)
            for (int q = 0; q < p; q++)
                if (in_write_ena[q] && in_write_ena[p] && addr[q] == addr[p]) lost[p] = 1'b1;
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        rd_data_d = '0;
        rd_valid_d = '0;
        col_d = '0;
        err_d = '0;
        if (state_q == CLEAR) begin
            mem_d[cnt_q[ADDR_BITS-1:0]] = '0;
            cnt_d = cnt_q + CNT_BITS'(1);
            state_d = (cnt_q == CNT_BITS'(NUM_WORDS - 1)) ? IDLE : CLEAR;
        end else begin
            state_d = in_clear ? CLEAR : IDLE;
            cnt_d = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                err_d[p] = (in_read_ena[p] | in_write_ena[p]) & ~in_rng[p];
                col_d[p] = in_write_ena[p] & in_rng[p] & lost[p];
                if (in_write_ena[p] && in_rng[p] && !lost[p])
                    for (int b = 0; b < NUM_BYTES; b++)
                        if (in_byte_ena[p*NUM_BYTES + b])
                            mem_d[addr[p]][b*BYTE_BITS +: BYTE_BITS] = in_data[p*WORD_BITS + b*BYTE_BITS +: BYTE_BITS];
            end
            // mem_d already carries the winning writers' bytes, which is the write-first view
            for (int p = 0; p < NUM_PORTS; p++)
                if (in_read_ena[p] && in_rng[p]) begin
                    rd_valid_d[p] = 1'b1;
                    rd_data_d[p*WORD_BITS +: WORD_BITS] = WRITE_FIRST ? mem_d[addr[p]] : mem_q[addr[p]];
                end
        end
    end
    always_ff @(posedge in_clk or posedge in_rst)
        if (in_rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rd_data_q <= '0;
            rd_valid_q <= '0;
            col_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            col_q <= col_d;
            err_q <= err_d;
        end
    always_ff @(posedge in_clk)
        mem_q <= mem_d;
    if (READ_LATENCY == 2) begin : g_lat2
        logic [NUM_PORTS*WORD_BITS-1:0] out_data_q;
        logic [NUM_PORTS-1:0]           out_valid_q;
        always_ff @(posedge in_clk or posedge in_rst)
            if (in_rst) begin
                out_data_q <= '0;
                out_valid_q <= '0;
            end else begin
                out_data_q <= rd_data_q;
                out_valid_q <= rd_valid_q;
            end
        assign out_data = out_data_q;
        assign out_valid = out_valid_q;
    end else begin : g_lat1
        assign out_data = rd_data_q;
        assign out_valid = rd_valid_q;
    end
    assign out_collision = col_q;
    assign out_err = err_q;
    assign out_busy = state_q == CLEAR;
endmodule

// File: tb/tb_ram_nport.sv
// tb_ram_nport: directed checks of a default ram_nport and a 16-bit, 6-word, write-first, latency-2 variant
module tb_ram_nport;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_clear, b_clear;
    logic [1:0]  a_re, a_we, a_be, b_re, b_we;
    logic [3:0]  b_be;
    logic [5:0]  a_addr, b_addr;
    logic [15:0] a_din, a_dout;
    logic [31:0] b_din, b_dout;
    logic [1:0]  a_valid, a_col, a_err, b_valid, b_col, b_err;
    logic        a_busy, b_busy;
    int          errors = 0;
    int          checks = 0;
    always #5 clk = ~clk;
    ram_nport dut_a (
        .in_clk(clk), .in_rst(rst), .in_clear(a_clear), .in_read_ena(a_re), .in_write_ena(a_we),
        .in_byte_ena(a_be), .in_addr(a_addr), .in_data(a_din), .out_data(a_dout), .out_valid(a_valid),
        .out_collision(a_col), .out_err(a_err), .out_busy(a_busy)
    );
    ram_nport #(.ADDR_BITS(3), .WORD_BITS(16), .BYTE_BITS(8), .NUM_WORDS(6), .NUM_PORTS(2),
                .READ_LATENCY(2), .WRITE_FIRST(1'b1)) dut_b (
        .in_clk(clk), .in_rst(rst), .in_clear(b_clear), .in_read_ena(b_re), .in_write_ena(b_we),
        .in_byte_ena(b_be), .in_addr(b_addr), .in_data(b_din), .out_data(b_dout), .out_valid(b_valid),
        .out_collision(b_col), .out_err(b_err), .out_busy(b_busy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        a_clear = 0; a_re = 0; a_we = 0; a_be = 0; a_addr = 0; a_din = 0;
        b_clear = 0; b_re = 0; b_we = 0; b_be = 0; b_addr = 0; b_din = 0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [7:0] after_abort(input int k);
        return (k < 3) ? 8'h00 : 8'(16 + k);
    endfunction
    initial begin
        rst = 0;
        idle();
        #2 rst = 1;
        #10;
        chk("rst_a_data", a_dout, 0);
        chk("rst_a_flags", {a_valid, a_col, a_err, a_busy}, 0);
        chk("rst_b_flags", {b_dout[0], b_valid, b_col, b_err, b_busy}, 0);
        @(posedge clk);
        #1 rst = 0;
        a_re = 2'b11; a_addr = {3'd3, 3'd3};
        tick();
        chk("a_init_data", a_dout, 16'hFFFF);
        chk("a_init_valid", a_valid, 2'b11);
        idle();
        a_we = 2'b11; a_be = 2'b11; a_addr = {3'd2, 3'd2}; a_din = {8'h3C, 8'hA5};
        tick();
        chk("a_col_flag", a_col, 2'b10);
        chk("a_col_err", a_err, 2'b00);
        idle();
        a_re = 2'b10; a_addr = {3'd2, 3'd0};
        tick();
        chk("a_col_data", a_dout, 16'hA500);
        chk("a_col_valid", {a_valid, a_col}, {2'b10, 2'b00});
        idle();
        a_we = 2'b01; a_be = 2'b01; a_din = 16'h0055; a_re = 2'b10; a_addr = {3'd4, 3'd4};
        tick();
        chk("a_rdw_old", a_dout, 16'hFF00);
        idle();
        a_re = 2'b01; a_addr = {3'd0, 3'd4};
        tick();
        chk("a_rdw_after", a_dout, 16'h0055);
        idle();
        a_re = 2'b01; a_addr = {3'd0, 3'd5};
        tick();
        chk("a_pre_rst_read", {a_valid, a_dout}, {2'b01, 16'h00FF});
        idle();
        rst = 1;
        #1;
        chk("a_rst_mid_read", {a_valid, a_dout}, 0);
        rst = 0;
        b_we = 2'b01; b_be = 4'b0011; b_addr = {3'd0, 3'd1}; b_din = 32'h0000_1234;
        tick();
        b_be = 4'b0001; b_din = 32'h0000_ABCD;
        tick();
        idle();
        b_re = 2'b01; b_addr = {3'd0, 3'd1};
        tick();
        idle();
        chk("b_lat2_gap", b_valid, 2'b00);
        tick();
        chk("b_byte_mask", b_dout, 32'h0000_12CD);
        chk("b_byte_valid", b_valid, 2'b01);
        b_we = 2'b01; b_be = 4'b0001; b_din = 32'h0000_0055; b_re = 2'b10; b_addr = {3'd4, 3'd4};
        tick();
        idle();
        chk("b_rdw_gap", b_valid, 2'b00);
        tick();
        chk("b_rdw_new", b_dout, 32'hFF55_0000);
        chk("b_rdw_valid", b_valid, 2'b10);
        b_we = 2'b11; b_be = 4'b1001; b_addr = {3'd0, 3'd0}; b_din = 32'hBB00_00AA;
        tick();
        chk("b_col_nonoverlap", b_col, 2'b10);
        idle();
        b_re = 2'b01;
        tick();
        idle();
        tick();
        chk("b_col_data", b_dout, 32'h0000_FFAA);
        b_we = 2'b01; b_re = 2'b11; b_be = 4'b0011; b_addr = {3'd7, 3'd7}; b_din = 32'h0000_1111;
        tick();
        chk("b_oor_err", {b_err, b_col}, {2'b11, 2'b00});
        idle();
        tick();
        chk("b_oor_read", {b_valid, b_dout}, 0);
        chk("b_oor_err_pulse", b_err, 2'b00);
        b_re = 2'b11; b_addr = {3'd5, 3'd1};
        tick();
        idle();
        tick();
        chk("b_oor_mem_kept", b_dout, 32'hFFFF_12CD);
        a_clear = 1;
        tick();
        a_clear = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_busy_c%0d", i), {a_busy, a_valid}, {1'b1, 2'b00});
            a_re = 2'b11; a_addr = {3'd6, 3'd4};
            tick();
        end
        idle();
        chk("a_busy_end", {a_busy, a_valid}, {1'b0, 2'b00});
        for (int w = 0; w < 4; w++) begin
            a_re = 2'b11; a_addr = {3'(2*w+1), 3'(2*w)};
            tick();
            chk($sformatf("a_cleared_w%0d", w), {a_valid, a_dout}, {2'b11, 16'h0000});
        end
        idle();
        for (int w = 0; w < 4; w++) begin
            a_we = 2'b11; a_be = 2'b11; a_addr = {3'(2*w+1), 3'(2*w)};
            a_din = {8'(16 + 2*w + 1), 8'(16 + 2*w)};
            tick();
        end
        idle();
        a_clear = 1;
        tick();
        a_clear = 0;
        tick();
        tick();
        tick();
        chk("a_busy_c3", a_busy, 1'b1);
        rst = 1;
        #1;
        chk("a_abort_busy", a_busy, 1'b0);
        rst = 0;
        for (int w = 0; w < 4; w++) begin
            a_re = 2'b11; a_addr = {3'(2*w+1), 3'(2*w)};
            tick();
            chk($sformatf("a_abort_w%0d", w), a_dout, {after_abort(2*w+1), after_abort(2*w)});
        end
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
